// File: rtl/bit_exec_pkg.sv
// Shared definitions for the bit execution unit: opcodes, FSM encoding and default widths.
package bit_exec_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 4;
    localparam int DEFAULT_CNT_WIDTH  = 8;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOT  = 3'd6,
        OP_MOV  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bit_exec_unit_if.sv
// Command handshake between the decode path (master) and the bit execution unit (slave).
interface bit_exec_unit_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_op;
    logic [ADDR_WIDTH-1:0] cmd_src_a;
    logic [ADDR_WIDTH-1:0] cmd_src_b;
    logic [ADDR_WIDTH-1:0] cmd_dest;

    modport master (
        output cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dest,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dest,
        output cmd_ready
    );
endinterface

// File: rtl/bit_logic_fn.sv
// Pure combinational single-bit logic function selected by opcode.
module bit_logic_fn
    import bit_exec_pkg::*;
(
    input  logic [2:0] op,
    input  logic       a,
    input  logic       b,
    output logic       y
);

    always_comb begin
        y = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            OP_NOT:  y = ~a;
            OP_MOV:  y = a;
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/bit_exec_unit.sv
// Sequencer for a 1-bit 2R/1W register RAM: read two operands, apply a logic op, write back.
// All RAM-facing outputs are driven straight from flops so the RAM never sees glitches.
module bit_exec_unit
    import bit_exec_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bit_exec_unit_if.slave        cmd,
    output logic [ADDR_WIDTH-1:0] ram_address_a,
    output logic [ADDR_WIDTH-1:0] ram_address_b,
    output logic [ADDR_WIDTH-1:0] ram_dest,
    output logic                  ram_data,
    output logic                  ram_we,
    input  logic                  ram_out_a,
    input  logic                  ram_out_b,
    output logic                  done,
    output logic                  result,
    output logic [CNT_WIDTH-1:0]  op_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    state_t                state_reg;
    state_t                state_next;
    logic                  accept;
    logic [2:0]            op_reg;
    logic [ADDR_WIDTH-1:0] src_a_reg;
    logic [ADDR_WIDTH-1:0] src_b_reg;
    logic [ADDR_WIDTH-1:0] dest_reg;
    logic                  calc_reg;
    logic                  we_reg;
    logic                  ready_reg;
    logic                  done_reg;
    logic                  result_reg;
    logic [CNT_WIDTH-1:0]  count_reg;
    logic                  fn_y;

    bit_logic_fn u_fn (
        .op (op_reg),
        .a  (ram_out_a),
        .b  (ram_out_b),
        .y  (fn_y)
    );

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    state_next = READ;
                    accept     = 1'b1;
                end
            end
            READ:    state_next = WRITE;
            WRITE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            src_a_reg  <= '0;
            src_b_reg  <= '0;
            dest_reg   <= '0;
            calc_reg   <= 1'b0;
            we_reg     <= 1'b0;
            ready_reg  <= 1'b1;
            done_reg   <= 1'b0;
            result_reg <= 1'b0;
            count_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ready_reg <= (state_next == IDLE);
            we_reg    <= (state_next == WRITE);
            done_reg  <= (state_next == DONE);
            if (accept) begin
                op_reg    <= cmd.cmd_op;
                src_a_reg <= cmd.cmd_src_a;
                src_b_reg <= cmd.cmd_src_b;
                dest_reg  <= cmd.cmd_dest;
            end
            if (state_reg == READ) begin
                calc_reg <= fn_y;
            end
            if (state_reg == WRITE) begin
                result_reg <= calc_reg;
                if (count_reg != '1) begin
                    count_reg <= count_reg + CNT_ONE;
                end
            end
        end
    end

    assign cmd.cmd_ready = ready_reg;
    assign ram_address_a = src_a_reg;
    assign ram_address_b = src_b_reg;
    assign ram_dest      = dest_reg;
    assign ram_data      = calc_reg;
    assign ram_we        = we_reg;
    assign done          = done_reg;
    assign result        = result_reg;
    assign op_count      = count_reg;

endmodule

// File: tb/tb_bit_exec_unit.sv
// Directed bench for bit_exec_unit with behavioural 16x1 RAMs (combinational read, falling-edge write).
module tb_bit_exec_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit_exec_unit_if #(.ADDR_WIDTH(4)) c1 ();
    bit_exec_unit_if #(.ADDR_WIDTH(4)) c2 ();

    logic [3:0] ra1, rb1, rd1, ra2, rb2, rd2;
    logic       rdat1, rwe1, done1, res1, rdat2, rwe2, done2, res2;
    logic [7:0] cnt1;
    logic [1:0] cnt2;
    logic       mem1 [16];
    logic       mem2 [16];
    int         wr1 = 0;

    always @(negedge clk) begin
        if (rwe1) begin
            mem1[rd1] <= rdat1;
            wr1 <= wr1 + 1;
        end
        if (rwe2) mem2[rd2] <= rdat2;
    end

    bit_exec_unit #(.ADDR_WIDTH(4), .CNT_WIDTH(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .cmd(c1),
        .ram_address_a(ra1), .ram_address_b(rb1), .ram_dest(rd1),
        .ram_data(rdat1), .ram_we(rwe1),
        .ram_out_a(mem1[ra1]), .ram_out_b(mem1[rb1]),
        .done(done1), .result(res1), .op_count(cnt1)
    );

    bit_exec_unit #(.ADDR_WIDTH(4), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .cmd(c2),
        .ram_address_a(ra2), .ram_address_b(rb2), .ram_dest(rd2),
        .ram_data(rdat2), .ram_we(rwe2),
        .ram_out_a(mem2[ra2]), .ram_out_b(mem2[rb2]),
        .done(done2), .result(res2), .op_count(cnt2)
    );

    // Issue one command on dut1 from IDLE and step to the following IDLE cycle, tallying strobes.
    task automatic exec1(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] d, output int busy, output int we, output int dn,
                         output logic rdy_end);
        busy = 0; we = 0; dn = 0;
        c1.cmd_op = op; c1.cmd_src_a = a; c1.cmd_src_b = b; c1.cmd_dest = d;
        c1.cmd_valid = 1'b1;
        @(posedge clk); #1;
        c1.cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            if (c1.cmd_ready === 1'b0) busy++;
            if (rwe1 === 1'b1) we++;
            if (done1 === 1'b1) dn++;
        end
        rdy_end = c1.cmd_ready;
        $display("cmd op=%0d a=%0d b=%0d dest=%0d -> result=%b count=%0d", op, a, b, d, res1, cnt1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        c1.cmd_valid = 1'b0; c1.cmd_op = '0; c1.cmd_src_a = '0; c1.cmd_src_b = '0; c1.cmd_dest = '0;
        c2.cmd_valid = 1'b0; c2.cmd_op = '0; c2.cmd_src_a = '0; c2.cmd_src_b = '0; c2.cmd_dest = '0;
        for (int i = 0; i < 16; i++) begin mem1[i] = 1'b0; mem2[i] = 1'b0; end
        mem1[0] = 1; mem1[3] = 1; mem1[5] = 1; mem1[6] = 1; mem1[7] = 1;
        mem2[0] = 1; mem2[3] = 1; mem2[5] = 1; mem2[6] = 1; mem2[7] = 1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (c1.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", c1.cmd_ready); end
        checks++; if (rwe1 !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", rwe1); end
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done1); end
        checks++; if (res1 !== 1'b0) begin errors++; $display("FAIL rst_result: got %b want 0", res1); end
        checks++; if (cnt1 !== 8'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", cnt1); end
        checks++; if ({ra1, rb1, rd1, rdat1} !== 13'd0) begin errors++; $display("FAIL rst_ram_bus: got %h want 0", {ra1, rb1, rd1, rdat1}); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (c1.cmd_ready !== 1'b1 || rwe1 !== 1'b0) begin errors++; $display("FAIL rst_idle: got ready=%b we=%b want 1/0", c1.cmd_ready, rwe1); end
        $display("reset released");
    endtask

    task automatic test_and();
        c1.cmd_op = 3'd0; c1.cmd_src_a = 4'd0; c1.cmd_src_b = 4'd3; c1.cmd_dest = 4'd8;
        c1.cmd_valid = 1'b1;
        @(posedge clk); #1;
        c1.cmd_valid = 1'b0;
        checks++; if (c1.cmd_ready !== 1'b0 || rwe1 !== 1'b0) begin errors++; $display("FAIL and_read_strobes: got ready=%b we=%b want 0/0", c1.cmd_ready, rwe1); end
        checks++; if (ra1 !== 4'd0 || rb1 !== 4'd3) begin errors++; $display("FAIL and_read_addr: got %0d,%0d want 0,3", ra1, rb1); end
        @(posedge clk); #1;
        checks++; if (rwe1 !== 1'b1 || rd1 !== 4'd8 || rdat1 !== 1'b1) begin errors++; $display("FAIL and_write: got we=%b dest=%0d data=%b want 1/8/1", rwe1, rd1, rdat1); end
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL and_early_done: got %b want 0", done1); end
        @(posedge clk); #1;
        checks++; if (rwe1 !== 1'b0 || done1 !== 1'b1) begin errors++; $display("FAIL and_done: got we=%b done=%b want 0/1", rwe1, done1); end
        checks++; if (res1 !== 1'b1 || cnt1 !== 8'd1) begin errors++; $display("FAIL and_result_count: got %b/%0d want 1/1", res1, cnt1); end
        checks++; if (mem1[8] !== 1'b1) begin errors++; $display("FAIL and_mem8: got %b want 1", mem1[8]); end
        @(posedge clk); #1;
        checks++; if (done1 !== 1'b0 || c1.cmd_ready !== 1'b1) begin errors++; $display("FAIL and_retire: got done=%b ready=%b want 0/1", done1, c1.cmd_ready); end
        $display("cmd AND 0,3 -> 8 result=%b count=%0d", res1, cnt1);
    endtask

    task automatic test_back_to_back();
        int busy, we, dn;
        logic rdy;
        exec1(3'd2, 4'd0, 4'd5, 4'd1, busy, we, dn, rdy);
        checks++; if (busy !== 3 || we !== 1 || dn !== 1 || rdy !== 1'b1) begin errors++; $display("FAIL b2b_xor_timing: got busy=%0d we=%0d done=%0d ready=%b want 3/1/1/1", busy, we, dn, rdy); end
        exec1(3'd7, 4'd1, 4'd0, 4'd9, busy, we, dn, rdy);
        checks++; if (busy !== 3 || we !== 1 || dn !== 1 || rdy !== 1'b1) begin errors++; $display("FAIL b2b_mov_timing: got busy=%0d we=%0d done=%0d ready=%b want 3/1/1/1", busy, we, dn, rdy); end
        checks++; if (mem1[1] !== 1'b0 || mem1[9] !== 1'b0) begin errors++; $display("FAIL b2b_mem1_mem9: got %b,%b want 0,0", mem1[1], mem1[9]); end
        exec1(3'd1, 4'd0, 4'd1, 4'd12, busy, we, dn, rdy);
        exec1(3'd7, 4'd12, 4'd0, 4'd13, busy, we, dn, rdy);
        checks++; if (mem1[12] !== 1'b1 || mem1[13] !== 1'b1 || res1 !== 1'b1) begin errors++; $display("FAIL b2b_raw: got mem12=%b mem13=%b result=%b want 1/1/1", mem1[12], mem1[13], res1); end
    endtask

    task automatic test_src_eq_dest();
        int busy, we, dn;
        logic rdy;
        exec1(3'd4, 4'd1, 4'd2, 4'd2, busy, we, dn, rdy);
        checks++; if (mem1[2] !== 1'b1 || res1 !== 1'b1) begin errors++; $display("FAIL nor_same_addr: got mem2=%b result=%b want 1/1", mem1[2], res1); end
        exec1(3'd5, 4'd1, 4'd4, 4'd14, busy, we, dn, rdy);
        checks++; if (mem1[14] !== 1'b1 || cnt1 !== 8'd7) begin errors++; $display("FAIL xnor_mem14: got mem14=%b count=%0d want 1/7", mem1[14], cnt1); end
    endtask

    task automatic test_valid_held();
        int w0;
        w0 = wr1;
        c1.cmd_op = 3'd6; c1.cmd_src_a = 4'd7; c1.cmd_src_b = 4'd0; c1.cmd_dest = 4'd10;
        c1.cmd_valid = 1'b1;
        @(posedge clk); #1;
        c1.cmd_op = 3'd7; c1.cmd_src_a = 4'd0; c1.cmd_dest = 4'd11;
        @(posedge clk); #1;
        checks++; if (rwe1 !== 1'b1 || rd1 !== 4'd10 || rdat1 !== 1'b0) begin errors++; $display("FAIL held_write: got we=%b dest=%0d data=%b want 1/10/0", rwe1, rd1, rdat1); end
        @(posedge clk); #1;
        checks++; if (done1 !== 1'b1 || res1 !== 1'b0) begin errors++; $display("FAIL held_done: got done=%b result=%b want 1/0", done1, res1); end
        c1.cmd_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (c1.cmd_ready !== 1'b1 || rwe1 !== 1'b0) begin errors++; $display("FAIL held_idle: got ready=%b we=%b want 1/0", c1.cmd_ready, rwe1); end
        checks++; if (mem1[10] !== 1'b0 || mem1[11] !== 1'b0 || wr1 - w0 !== 1) begin errors++; $display("FAIL held_single: got mem10=%b mem11=%b writes=%0d want 0/0/1", mem1[10], mem1[11], wr1 - w0); end
        $display("cmd NOT 7 -> 10 (valid held) result=%b", res1);
    endtask

    task automatic test_reset_mid();
        int w0;
        c1.cmd_op = 3'd3; c1.cmd_src_a = 4'd5; c1.cmd_src_b = 4'd6; c1.cmd_dest = 4'd11;
        c1.cmd_valid = 1'b1;
        @(posedge clk); #1;
        c1.cmd_valid = 1'b0;
        w0 = wr1;
        @(posedge clk); #1;
        checks++; if (rwe1 !== 1'b1 || rd1 !== 4'd11 || rdat1 !== 1'b0) begin errors++; $display("FAIL mid_write: got we=%b dest=%0d data=%b want 1/11/0", rwe1, rd1, rdat1); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (rwe1 !== 1'b0) begin errors++; $display("FAIL mid_async_we: got %b want 0", rwe1); end
        checks++; if (c1.cmd_ready !== 1'b1 || cnt1 !== 8'd0 || done1 !== 1'b0) begin errors++; $display("FAIL mid_async_state: got ready=%b count=%0d done=%b want 1/0/0", c1.cmd_ready, cnt1, done1); end
        @(posedge clk); #1;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (done1 !== 1'b0 || c1.cmd_ready !== 1'b1 || cnt1 !== 8'd0) begin errors++; $display("FAIL mid_after: got done=%b ready=%b count=%0d want 0/1/0", done1, c1.cmd_ready, cnt1); end
        checks++; if (mem1[11] !== 1'b0 || wr1 !== w0) begin errors++; $display("FAIL mid_no_write: got mem11=%b writes=%0d want 0/%0d", mem1[11], wr1, w0); end
        $display("cmd NAND 5,6 -> 11 aborted by reset");
    endtask

    task automatic test_saturate();
        logic [2:0] ops  [5] = '{3'd5, 3'd0, 3'd1, 3'd2, 3'd4};
        logic [3:0] srca [5] = '{4'd1, 4'd0, 4'd1, 4'd3, 4'd2};
        logic [3:0] srcb [5] = '{4'd4, 4'd1, 4'd3, 4'd5, 4'd4};
        logic       expv [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0] expc [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        int dones;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            c2.cmd_op = ops[i]; c2.cmd_src_a = srca[i]; c2.cmd_src_b = srcb[i]; c2.cmd_dest = 4'd15;
            c2.cmd_valid = 1'b1;
            @(posedge clk); #1;
            c2.cmd_valid = 1'b0;
            @(posedge clk); #1;
            checks++; if (rwe2 !== 1'b1 || rdat2 !== expv[i]) begin errors++; $display("FAIL sat_write[%0d]: got we=%b data=%b want 1/%b", i, rwe2, rdat2, expv[i]); end
            @(posedge clk); #1;
            if (done2 === 1'b1) dones++;
            checks++; if (cnt2 !== expc[i] || res2 !== expv[i]) begin errors++; $display("FAIL sat_count[%0d]: got count=%0d result=%b want %0d/%b", i, cnt2, res2, expc[i], expv[i]); end
            @(posedge clk); #1;
            $display("cmd2 op=%0d a=%0d b=%0d -> result=%b count=%0d", ops[i], srca[i], srcb[i], res2, cnt2);
        end
        checks++; if (dones !== 5) begin errors++; $display("FAIL sat_done_pulses: got %0d want 5", dones); end
    endtask

    initial begin
        test_reset();
        test_and();
        test_back_to_back();
        test_src_eq_dest();
        test_valid_held();
        test_reset_mid();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
